// File: rtl/seq_mul_pkg.sv
// Shared constants and state encoding for the sequential shift-and-add multiplier.
package seq_mul_pkg;
    localparam int MUL_W    = 32;
    localparam int CNT_W    = 6;
    localparam int MUL_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);
endpackage

// File: rtl/full_adder_32_bit.sv
// 32-bit ripple-carry adder; the multiplier's only arithmetic resource.
module full_adder_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);
    logic carry;

    always_comb begin
        s     = '0;
        carry = cin;
        for (int i = 0; i < 32; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end
endmodule

// File: rtl/seq_mul_ctrl.sv
// Sequential unsigned 32x32->64 multiplier: one conditional add-and-shift per clock.
// Optional SEQ_MUL_EARLY_TERM_EN: zero operand at accept skips the 32 iterations.
//
// state   | meaning
// ST_IDLE | waiting for start; operands captured on accept
// ST_RUN  | one add-and-shift per cycle, cnt counts 0..31
// ST_DONE | done pulse cycle, product valid; always returns to IDLE
module seq_mul_ctrl
    import seq_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);
    state_t             state_q, state_d;
    logic [MUL_W-1:0]   m_q, m_d;
    logic [MUL_W-1:0]   acc_q, acc_d;
    logic [MUL_W-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*MUL_W-1:0] product_q, product_d;

    logic [MUL_W-1:0]   add_sum;
    logic               add_cout;
    logic [2*MUL_W-1:0] shifted;

    full_adder_32_bit u_adder (
        .a    (acc_q),
        .b    (q_q[0] ? m_q : '0),
        .cin  (1'b0),
        .s    (add_sum),
        .cout (add_cout)
    );

    // The carry column above acc is always zero after the shift, so acc keeps 32 bits.
    assign shifted = {add_cout, add_sum, q_q[MUL_W-1:1]};

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
`ifdef SEQ_MUL_EARLY_TERM_EN
                    // Zero product: a single silent pass of zeros lands in DONE one edge later.
                    if (a == '0 || b == '0) begin
                        m_d    = '0;
                        q_d    = '0;
                        cnt_d  = CNT_LAST;
                        busy_d = 1'b0;
                    end
`endif
                end
            end
            ST_RUN: begin
                acc_d = shifted[2*MUL_W-1:MUL_W];
                q_d   = shifted[MUL_W-1:0];
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == CNT_LAST) begin
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    product_d = shifted;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
endmodule
